pixel_word_packer: RTL
======================

Name: pixel_word_packer

Overview:
- Upstream feeder for the image cache loader stage.
- Accepts a raster pixel stream, PIX_WIDTH bits per pixel, with valid/ready and start-of-frame.
- Packs pixels into WORD_SIZE-bit words, little-endian by lane: the first pixel goes to bits [PIX_WIDTH-1:0].
- Presents the words on the data / data_ready / data_wanted port the loader consumes. Provides frame alignment, end-of-frame zero-padding and a 2-entry output skid FIFO.

Parameters:
- PIX_WIDTH, 8: bits per input pixel.
- WORD_SIZE, 32: output word width. Must be an integer multiple of PIX_WIDTH; LANES = WORD_SIZE/PIX_WIDTH.
- FRAME_PIXELS, 1024: pixels per frame (ROW_WIDTH*COL_WIDTH of the cache). Must be ≥1.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- pix  input  PIX_WIDTH  pixel data.
- pix_valid  input  1  pixel present.
- pix_sof  input  1  qualifies pix as first pixel of a frame.
- pix_ready  output  1  pixel accepted when pix_valid && pix_ready.
- data  output  WORD_SIZE  packed word (FIFO head).
- data_ready  output  1  word available.
- data_wanted  input  1  consumer takes word when data_ready && data_wanted.
- frame_done  output  1  one-cycle pulse when the final word of a frame is taken.
- sync_err  output  1  sticky flag, set on pix_sof mid-frame.

Behaviour:
- Reset, asynchronous: state=IDLE, lane=0, pix_cnt=0, FIFO empty, pack register 0. Outputs: data_ready=0, data=0, frame_done=0, sync_err=0. pix_ready=1 in IDLE.
- A reset mid-frame discards the partial word and all FIFO contents. No frame_done is generated.
- State IDLE:
  - pix_ready=1.
  - Accepted pixels without pix_sof are dropped.
  - An accepted pixel with pix_sof is written to lane 0, lane=1, pix_cnt=1, and the state goes to PACK.
  - If FRAME_PIXELS==1 or LANES==1, the word is pushed immediately (rules below).
- State PACK:
  - pix_ready = !fifo_full.
  - Each accepted pixel is written to lane `lane`; lane increments and pix_cnt increments.
  - When lane reaches LANES-1 with an accept, the word is pushed to the FIFO and lane wraps to 0.
  - When pix_cnt reaches FRAME_PIXELS with an accept, the partial word is pushed with unused upper lanes zeroed. That word is tagged last, the state returns to IDLE, and lane and pix_cnt clear.
  - An accepted pix_sof while in PACK:
    - sync_err is set (stays set until reset).
    - The partial word is discarded and no word is pushed for it.
    - The pixel restarts a frame: lane 0, pix_cnt=1, stay in PACK.
    - Previously pushed words remain in the FIFO.
- FIFO:
  - 2 entries of {last, word}; data shows the head entry.
  - data_ready = count!=0.
  - Push and pop in the same cycle: count unchanged and order preserved.
  - Pop when empty is impossible because it is gated by data_ready.
  - fifo_full = count==2, which forces pix_ready=0.
- Latency: the word becomes visible with data_ready=1 on the clock edge after the accept of the pixel that completes it.
- Throughput: one word per LANES cycles, sustained with data_wanted held at 1.
- frame_done:
  - Registered; asserts for one cycle in the cycle after a pop of a last-tagged entry.
  - Back-to-back frames produce separate pulses.
- data and pix are never X-propagated from unused lanes; padded lanes are always 0.

Optional Feature:
- Macro: PACKER_STATS_EN.
- When defined:
  - Adds output word_count [31:0], which increments on every pop and wraps at 2^32.
  - Adds output drop_count [15:0], which increments on every pixel dropped in IDLE and saturates at 0xFFFF.
  - Both clear on reset.
- When undefined: neither port nor counter exists, and behaviour is otherwise identical.

Test Plan:
- Normal frame. Setup: FRAME_PIXELS=8, pixels 0x01..0x08 with sof on the first, data_wanted=1. Expected: words 0x04030201 and 0x08070605; frame_done pulses once, 1 cycle after the second pop; sync_err=0.
- Padding. Setup: FRAME_PIXELS=6, pixels 0xA1..0xA6. Expected: words 0xA4A3A2A1 and 0x0000A6A5; last word tagged; frame_done=1 once.
- Backpressure. Setup: data_wanted=0, stream 12 pixels. Expected: pix_ready drops to 0 after the 8th accept (FIFO full); data holds the first word. Then data_wanted=1: words emerge in order with none lost or duplicated.
- Pre-frame drop and resync. Setup: 3 pixels without sof in IDLE, then a normal frame. Expected: the 3 pixels are dropped. A sof at the 2nd pixel of a later frame gives sync_err=1 and the partial word is discarded; the new frame packs from lane 0.
- Reset mid-frame. Setup: assert reset after 5 pixels with 1 word queued. Expected: immediately data_ready=0, pix_ready=1, sync_err=0; no frame_done. A subsequent sof frame packs correctly.
- PACKER_STATS_EN. Setup: run the two-word frame, then drop 2 pixels. Expected: word_count=2, drop_count=2.

Source files
------------

// File: rtl/pixel_word_packer_if.sv
// Pixel-in / word-out handshake bundle for pixel_word_packer.
// master drives pixels and consumes words; slave is the packer.
interface pixel_word_packer_if #(
  parameter int PIX_WIDTH = 8,
  parameter int WORD_SIZE = 32
);
  logic [PIX_WIDTH-1:0] pix;
  logic                 pix_valid;
  logic                 pix_sof;
  logic                 pix_ready;
  logic [WORD_SIZE-1:0] data;
  logic                 data_ready;
  logic                 data_wanted;

  modport master (
    output pix, pix_valid, pix_sof, data_wanted,
    input  pix_ready, data, data_ready
  );
  modport slave (
    input  pix, pix_valid, pix_sof, data_wanted,
    output pix_ready, data, data_ready
  );
endinterface

// File: rtl/pixel_word_packer.sv
// Packs a framed pixel stream into little-endian words behind a 2-entry skid FIFO.
// Optional PACKER_STATS_EN adds word_count / drop_count outputs.

// One lane of the pack register; nxt is the lane value including this cycle's write.
module pixel_word_packer_lane #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic         clr,
  input  logic         flush,
  input  logic [W-1:0] d,
  output logic [W-1:0] nxt
);
  logic [W-1:0] q;

  assign nxt = ld ? d : (clr ? '0 : q);

  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else     q <= flush ? '0 : nxt;
endmodule

module pixel_word_packer #(
  parameter int PIX_WIDTH    = 8,
  parameter int WORD_SIZE    = 32,
  parameter int FRAME_PIXELS = 1024
) (
  input  logic               clk,
  input  logic               reset,
  pixel_word_packer_if.slave bus,
  output logic               frame_done,
  output logic               sync_err
`ifdef PACKER_STATS_EN
  ,
  output logic [31:0]        word_count,
  output logic [15:0]        drop_count
`endif
);
  localparam int LANES    = WORD_SIZE / PIX_WIDTH;
  localparam int LW       = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CW       = $clog2(FRAME_PIXELS + 1);
  localparam bit IMM_PUSH = (LANES == 1) || (FRAME_PIXELS == 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PACK = 1'b1;

  typedef struct packed {
    logic                 last;
    logic [WORD_SIZE-1:0] word;
  } entry_t;

  logic [0:0]    state;
  logic [LW-1:0] lane, wl;
  logic [CW-1:0] pix_cnt, cnt_n;
  logic          accept, start, cont, take, end_frame, word_full, push, pop;
  logic          fifo_full;
  logic          rd_ptr, wr_ptr;
  logic [1:0]    count;
  entry_t        fifo [2];

  logic [LANES-1:0]                ld;
  logic [LANES-1:0][PIX_WIDTH-1:0] lane_nxt;

  // A start-pixel that pushes on its own cycle could overrun a full FIFO, so
  // IDLE only ignores fullness when a single pixel can never complete a word.
  assign fifo_full     = count == 2'd2;
  assign bus.pix_ready = (state == IDLE && !IMM_PUSH) || !fifo_full;

  assign accept    = bus.pix_valid && bus.pix_ready;
  assign start     = accept && bus.pix_sof;
  assign cont      = accept && !bus.pix_sof && state == PACK;
  assign take      = start || cont;
  assign wl        = start ? '0 : lane;
  assign cnt_n     = start ? CW'(1) : pix_cnt + CW'(1);
  assign end_frame = take && cnt_n == CW'(FRAME_PIXELS);
  assign word_full = take && wl == LW'(LANES - 1);
  assign push      = end_frame || word_full;
  assign pop       = bus.data_ready && bus.data_wanted;

  // start clears every lane it does not write: that is both the resync
  // discard and the guarantee that padded lanes read as zero.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign ld[i] = take && wl == LW'(i);
    pixel_word_packer_lane #(.W(PIX_WIDTH)) u_lane (
      .clk   (clk),
      .rst   (reset),
      .ld    (ld[i]),
      .clr   (start),
      .flush (push),
      .d     (bus.pix),
      .nxt   (lane_nxt[i])
    );
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state    <= IDLE;
      lane     <= '0;
      pix_cnt  <= '0;
      sync_err <= 1'b0;
    end else begin
      if (start && state == PACK) sync_err <= 1'b1;
      if (take) begin
        state   <= end_frame ? IDLE : PACK;
        lane    <= push ? '0 : wl + LW'(1);
        pix_cnt <= end_frame ? '0 : cnt_n;
      end
    end

  assign bus.data_ready = count != 2'd0;
  assign bus.data       = bus.data_ready ? fifo[rd_ptr].word : '0;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      fifo[0]    <= '0;
      fifo[1]    <= '0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      count      <= 2'd0;
      frame_done <= 1'b0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= {end_frame, lane_nxt};
        wr_ptr       <= !wr_ptr;
      end
      if (pop) rd_ptr <= !rd_ptr;
      count      <= count + 2'(push) - 2'(pop);
      frame_done <= pop && fifo[rd_ptr].last;
    end

`ifdef PACKER_STATS_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      word_count <= '0;
      drop_count <= '0;
    end else begin
      if (pop) word_count <= word_count + 32'd1;
      if (state == IDLE && accept && !bus.pix_sof && drop_count != 16'hFFFF)
        drop_count <= drop_count + 16'd1;
    end
`endif
endmodule
